pulse_gen: RTL and testbench

PULSE_GEN -- requirements
Module: pulse_gen

---
 rtl/pulse_gen.sv | 134 +++++++++++++
 tb/tb_pulse_gen.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/pulse_gen.sv
// rtl/pulse_gen.sv - triggered pulse generator with programmable high time and holdoff
//
// Purpose:
//   Accepts a level-sampled trigger while idle and produces one output pulse.
//   The pulse is high for max(hi_len,1) cycles. It is then followed by lo_len
//   holdoff cycles, during which the trigger is ignored.
//
// Ports:
//   clk        single clock, all state changes on posedge
//   rst        synchronous active-high reset
//   x_in       trigger, sampled every posedge
//   hi_len     pulse-high length in cycles (0 behaves as 1)
//   lo_len     holdoff length in cycles (0 means no holdoff)
//   y_out      generated pulse, decoded from the registered state
//   busy       high whenever the generator is not idle
//   done       one-cycle strobe in the cycle after the last high cycle
//   pulse_cnt  number of pulses started since reset, wraps
//
// Configuration:
//   PULSE_GEN_RETRIG_EN  when defined, a trigger seen while the pulse is high
//                        reloads the high counter from the current lengths
//                        and so stretches the pulse.

module pulse_gen #(
    parameter int CW  = 8,
    parameter int PCW = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           x_in,
    input  logic [CW-1:0]  hi_len,
    input  logic [CW-1:0]  lo_len,
    output logic           y_out,
    output logic           busy,
    output logic           done,
    output logic [PCW-1:0] pulse_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        HIGH = 2'b01,
        HOLD = 2'b10
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [CW-1:0]  lo_q, lo_d;
    logic           done_q, done_d;
    logic [PCW-1:0] pcnt_q, pcnt_d;
    logic [CW-1:0]  hi_load;
    logic           retrig;

    // The counter holds "cycles remaining minus one". A zero length is
    // therefore loaded as zero, which gives the single-cycle minimum.
    assign hi_load = (hi_len == '0) ? '0 : hi_len - CW'(1);

`ifdef PULSE_GEN_RETRIG_EN
    assign retrig = x_in;
`else
    assign retrig = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
            pcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            pcnt_q  <= pcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        pcnt_d  = pcnt_q;
        case (state_q)
            IDLE: begin
                if (x_in) begin
                    state_d = HIGH;
                    cnt_d   = hi_load;
                    lo_d    = lo_len;
                    pcnt_d  = pcnt_q + PCW'(1);
                end
            end
            HIGH: begin
                if (retrig) begin
                    // Stretch: restart the high phase from the current lengths.
                    // This is not a new pulse, so pcnt is left alone.
                    cnt_d = hi_load;
                    lo_d  = lo_len;
                end else if (cnt_q == '0) begin
                    // done is registered, so it appears in the cycle after the
                    // last high cycle, whichever state follows.
                    done_d = 1'b1;
                    if (lo_q != '0) begin
                        state_d = HOLD;
                        cnt_d   = lo_q - CW'(1);
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            HOLD: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                // The unused encoding recovers to idle on the next edge.
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign y_out     = (state_q == HIGH);
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign pulse_cnt = pcnt_q;

endmodule

// File: tb/tb_pulse_gen.sv
// tb/tb_pulse_gen.sv - directed self-checking bench for pulse_gen

module tb_pulse_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        x_in;
    logic [7:0]  hi_len;
    logic [7:0]  lo_len;
    logic        y_out, busy, done;
    logic [15:0] pulse_cnt;
    logic        y2, busy2, done2;
    logic [1:0]  pulse_cnt2;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pulse_gen #(.CW(8), .PCW(16)) dut (
        .clk(clk), .rst(rst), .x_in(x_in), .hi_len(hi_len), .lo_len(lo_len),
        .y_out(y_out), .busy(busy), .done(done), .pulse_cnt(pulse_cnt)
    );

    pulse_gen #(.CW(8), .PCW(2)) dut_narrow (
        .clk(clk), .rst(rst), .x_in(x_in), .hi_len(hi_len), .lo_len(lo_len),
        .y_out(y2), .busy(busy2), .done(done2), .pulse_cnt(pulse_cnt2)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one posedge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        x_in = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Counts outputs over n cycles, starting with the cycle currently visible.
    task automatic measure(input int n, output int ycnt, output int bcnt,
                           output int dcnt, output int didx);
        ycnt = 0; bcnt = 0; dcnt = 0; didx = -1;
        for (int i = 0; i < n; i++) begin
            if (y_out) ycnt++;
            if (busy) bcnt++;
            if (done) begin
                dcnt++;
                didx = i;
            end
            tick();
        end
    endtask

    int yc, bc, dc, di;
    int starts, ytot, first_start, second_start, third_start;
    logic y_prev;
    int exp_wrap [4] = '{1, 2, 3, 0};

    initial begin
        rst = 1'b1;
        x_in = 1'b1;
        hi_len = 8'd3;
        lo_len = 8'd2;
        // Reset must win over a trigger presented at the same edge.
        tick();
        tick();
        check("reset_y", y_out, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_cnt", pulse_cnt, 0);
        x_in = 1'b0;
        rst = 1'b0;

        // hi=3, lo=2, single trigger, lengths changed in flight
        hi_len = 8'd3; lo_len = 8'd2; x_in = 1'b1;
        tick();
        x_in = 1'b0;
        check("t1_first_y", y_out, 1);
        hi_len = 8'd7; lo_len = 8'd7;
        measure(20, yc, bc, dc, di);
        check("t1_y_cycles", yc, 3);
        check("t1_busy_cycles", bc, 5);
        check("t1_done_cycles", dc, 1);
        check("t1_done_pos", di, 3);
        check("t1_cnt", pulse_cnt, 1);

        // hi=0, lo=0: minimum one-cycle pulse, no holdoff
        hi_len = 8'd0; lo_len = 8'd0; x_in = 1'b1;
        tick();
        x_in = 1'b0;
        measure(10, yc, bc, dc, di);
        check("t2_y_cycles", yc, 1);
        check("t2_busy_cycles", bc, 1);
        check("t2_done_pos", di, 1);
        check("t2_cnt", pulse_cnt, 2);
        check("t2_idle", busy, 0);

        // reset on second high cycle aborts without done
        do_reset();
        hi_len = 8'd3; lo_len = 8'd2; x_in = 1'b1;
        tick();
        x_in = 1'b0;
        tick();
        check("t3_second_high", y_out, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t3_abort_y", y_out, 0);
        check("t3_abort_busy", busy, 0);
        measure(8, yc, bc, dc, di);
        check("t3_no_done", dc, 0);
        check("t3_cnt", pulse_cnt, 0);

        // trigger held high: accepted at sample indices 0, 6, 12
        do_reset();
        hi_len = 8'd3; lo_len = 8'd2;
        starts = 0; ytot = 0; y_prev = 1'b0;
        first_start = -1; second_start = -1; third_start = -1;
        x_in = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (i == 17) x_in = 1'b0;
            if (y_out) ytot++;
            if (y_out && !y_prev) begin
                starts++;
                if (starts == 1) first_start = i;
                if (starts == 2) second_start = i;
                if (starts == 3) third_start = i;
            end
            y_prev = y_out;
        end
`ifdef PULSE_GEN_RETRIG_EN
        check("t4_starts", starts, 1);
        check("t4_y_total", ytot, 20);
        check("t4_cnt", pulse_cnt, 1);
`else
        check("t4_starts", starts, 3);
        check("t4_y_total", ytot, 9);
        check("t4_first", first_start, 0);
        check("t4_spacing1", second_start - first_start, 6);
        check("t4_spacing2", third_start - second_start, 6);
        check("t4_cnt", pulse_cnt, 3);
`endif

        // second trigger sampled at the end of the second high cycle
        do_reset();
        hi_len = 8'd4; lo_len = 8'd1; x_in = 1'b1;
        tick();
        x_in = 1'b0;
        tick();
        x_in = 1'b1;
        tick();
        x_in = 1'b0;
        measure(20, yc, bc, dc, di);
`ifdef PULSE_GEN_RETRIG_EN
        check("t5_y_cycles", yc + 2, 6);
`else
        check("t5_y_cycles", yc + 2, 4);
`endif
        check("t5_done_cycles", dc, 1);
        check("t5_cnt", pulse_cnt, 1);

        // narrow counter wraps 1, 2, 3, 0
        do_reset();
        hi_len = 8'd1; lo_len = 8'd0;
        for (int k = 0; k < 4; k++) begin
            x_in = 1'b1;
            tick();
            x_in = 1'b0;
            measure(4, yc, bc, dc, di);
            check($sformatf("t6_wrap%0d", k), pulse_cnt2, exp_wrap[k]);
        end
        check("t6_wide_cnt", pulse_cnt, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
